// File: rtl/arm_ctrl_pkg.sv
// rtl/arm_ctrl_pkg.sv - shared opcodes, ALU command codes, mode codes and FSM state for the ID-stage controller
package arm_ctrl_pkg;

   localparam logic [1:0] MODE_ALU = 2'b00;
   localparam logic [1:0] MODE_MEM = 2'b01;
   localparam logic [1:0] MODE_BR  = 2'b10;
   localparam logic [1:0] MODE_NOP = 2'b11;

   localparam logic [3:0] OP_MOV  = 4'b1101;
   localparam logic [3:0] OP_MVN  = 4'b1111;
   localparam logic [3:0] OP_ADD  = 4'b0100;
   localparam logic [3:0] OP_ADC  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0010;
   localparam logic [3:0] OP_SBC  = 4'b0110;
   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_ORR  = 4'b1100;
   localparam logic [3:0] OP_EOR  = 4'b0001;
   localparam logic [3:0] OP_CMP  = 4'b1010;
   localparam logic [3:0] OP_TST  = 4'b1000;
   // In mode 01 this opcode selects the register-list PUSH/POP sequence
   localparam logic [3:0] OP_LIST = 4'b1111;

   localparam logic [3:0] EXE_NONE = 4'b0000;
   localparam logic [3:0] EXE_MOV  = 4'b0001;
   localparam logic [3:0] EXE_ADD  = 4'b0010;
   localparam logic [3:0] EXE_ADC  = 4'b0011;
   localparam logic [3:0] EXE_SUB  = 4'b0100;
   localparam logic [3:0] EXE_SBC  = 4'b0101;
   localparam logic [3:0] EXE_AND  = 4'b0110;
   localparam logic [3:0] EXE_ORR  = 4'b0111;
   localparam logic [3:0] EXE_EOR  = 4'b1000;
   localparam logic [3:0] EXE_MVN  = 4'b1001;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEQ  = 1'b1
   } state_t;

   typedef struct packed {
      logic [3:0] exe_cmd;
      logic       wb_en;
      logic       known;
      logic       is_test;
   } alu_dec_t;

   function automatic alu_dec_t alu_decode(input logic [3:0] op);
      alu_dec_t d;
      d = '{exe_cmd: EXE_NONE, wb_en: 1'b1, known: 1'b1, is_test: 1'b0};
      case (op)
         OP_MOV:  d.exe_cmd = EXE_MOV;
         OP_MVN:  d.exe_cmd = EXE_MVN;
         OP_ADD:  d.exe_cmd = EXE_ADD;
         OP_ADC:  d.exe_cmd = EXE_ADC;
         OP_SUB:  d.exe_cmd = EXE_SUB;
         OP_SBC:  d.exe_cmd = EXE_SBC;
         OP_AND:  d.exe_cmd = EXE_AND;
         OP_ORR:  d.exe_cmd = EXE_ORR;
         OP_EOR:  d.exe_cmd = EXE_EOR;
         OP_CMP: begin
            d.exe_cmd = EXE_SUB;
            d.wb_en   = 1'b0;
            d.is_test = 1'b1;
         end
         OP_TST: begin
            d.exe_cmd = EXE_AND;
            d.wb_en   = 1'b0;
            d.is_test = 1'b1;
         end
         default: d = '{exe_cmd: EXE_NONE, wb_en: 1'b0, known: 1'b0, is_test: 1'b0};
      endcase
      return d;
   endfunction

endpackage

// File: rtl/find_first_set.sv
// rtl/find_first_set.sv - index of the lowest set bit of a vector, plus a found flag
module find_first_set #(
   parameter int NUM_BITS = 16,
   parameter int IDX_W    = 4
) (
   input  logic [NUM_BITS-1:0] vec,
   output logic [IDX_W-1:0]    idx,
   output logic                found
);

   // Scan high to low so the lowest set bit is the last one written
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = NUM_BITS - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx   = IDX_W'(i);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/multi_cycle_controller.sv
// rtl/multi_cycle_controller.sv - ID-stage decoder with one-micro-op-per-cycle PUSH/POP sequencing
module multi_cycle_controller
   import arm_ctrl_pkg::*;
#(
   parameter int NUM_REGS   = 16,
   parameter int IDX_W      = 4,
   parameter int WORD_BYTES = 4,
   parameter int OFS_W      = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    valid,
   input  logic                    hazard,
   input  logic                    flush,
   input  logic [1:0]              mode,
   input  logic [3:0]              opcode,
   input  logic                    status,
   input  logic [NUM_REGS-1:0]     reg_list,
   output logic [3:0]              exe_cmd,
   output logic                    mem_read,
   output logic                    mem_write,
   output logic                    wb_en,
   output logic                    branch,
   output logic                    push,
   output logic                    pop,
   output logic                    status_update,
   output logic [IDX_W-1:0]        xfer_reg,
   output logic signed [OFS_W-1:0] xfer_offset,
   output logic                    sp_update,
   output logic signed [OFS_W-1:0] sp_delta,
   output logic                    stall,
   output logic                    busy
);

   localparam int CW = IDX_W + 1;

   state_t              state, state_nx;
   logic [NUM_REGS-1:0] rem_list, rem_nx;
   logic [IDX_W-1:0]    k, k_nx;
   logic [CW-1:0]       cnt, cnt_nx;
   logic                dir, dir_nx;

   logic [CW-1:0]       in_cnt;
   logic [NUM_REGS-1:0] ffs_vec;
   logic [IDX_W-1:0]    ffs_idx;
   logic                ffs_found;
   logic                is_list;
   logic                go;
   logic                uop_en;
   logic                uop_last;
   logic [CW-1:0]       uop_k;
   logic [CW-1:0]       uop_cnt;
   logic                uop_dir;
   alu_dec_t            alu_dec;

   logic signed [OFS_W-1:0] ofs_pop, ofs_push, delta_pop, delta_push;

   always_comb begin
      in_cnt = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         in_cnt = in_cnt + CW'(reg_list[i]);
      end
   end

   // In SEQ the IF/ID register is frozen, so only the latched list drives selection
   assign ffs_vec = (state == ST_SEQ) ? rem_list : reg_list;

   find_first_set #(
      .NUM_BITS (NUM_REGS),
      .IDX_W    (IDX_W)
   ) u_ffs (
      .vec   (ffs_vec),
      .idx   (ffs_idx),
      .found (ffs_found)
   );

   assign is_list  = (mode == MODE_MEM) && (opcode == OP_LIST);
   assign go       = rst && valid && !hazard && !flush;
   assign uop_k    = (state == ST_SEQ) ? CW'(k) : '0;
   assign uop_cnt  = (state == ST_SEQ) ? cnt : in_cnt;
   assign uop_dir  = (state == ST_SEQ) ? dir : status;
   assign uop_last = (uop_k + CW'(1)) == uop_cnt;
   assign uop_en   = go && ffs_found && ((state == ST_SEQ) || is_list);
   assign alu_dec  = alu_decode(opcode);

   // POP walks upward from SP; PUSH places the lowest register deepest below SP
   assign ofs_pop    = OFS_W'(int'(uop_k) * WORD_BYTES);
   assign ofs_push   = OFS_W'((int'(uop_k) - int'(uop_cnt)) * WORD_BYTES);
   assign delta_pop  = OFS_W'(int'(uop_cnt) * WORD_BYTES);
   assign delta_push = OFS_W'(-(int'(uop_cnt) * WORD_BYTES));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         rem_list <= '0;
         k        <= '0;
         cnt      <= '0;
         dir      <= 1'b0;
      end else begin
         state    <= state_nx;
         rem_list <= rem_nx;
         k        <= k_nx;
         cnt      <= cnt_nx;
         dir      <= dir_nx;
      end
   end

   always_comb begin
      state_nx = state;
      rem_nx   = rem_list;
      k_nx     = k;
      cnt_nx   = cnt;
      dir_nx   = dir;
      if (flush || (uop_en && uop_last) || ((state == ST_SEQ) && !ffs_found)) begin
         state_nx = ST_IDLE;
         rem_nx   = '0;
         k_nx     = '0;
         cnt_nx   = '0;
         dir_nx   = 1'b0;
      end else if (uop_en) begin
         state_nx = ST_SEQ;
         rem_nx   = ffs_vec & (ffs_vec - NUM_REGS'(1));
         k_nx     = (state == ST_SEQ) ? k + IDX_W'(1) : IDX_W'(1);
         cnt_nx   = uop_cnt;
         dir_nx   = uop_dir;
      end
   end

   always_comb begin
      exe_cmd       = EXE_NONE;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      wb_en         = 1'b0;
      branch        = 1'b0;
      push          = 1'b0;
      pop           = 1'b0;
      status_update = 1'b0;
      xfer_reg      = '0;
      xfer_offset   = '0;
      sp_update     = 1'b0;
      sp_delta      = '0;
      busy          = (state == ST_SEQ);
      stall         = (state == ST_SEQ) && !flush;
      if (uop_en) begin
         stall    = !uop_last;
         xfer_reg = ffs_idx;
         if (uop_dir) begin
            mem_read    = 1'b1;
            wb_en       = 1'b1;
            pop         = 1'b1;
            xfer_offset = ofs_pop;
         end else begin
            exe_cmd     = EXE_ADD;
            mem_write   = 1'b1;
            push        = 1'b1;
            xfer_offset = ofs_push;
         end
         if (uop_last) begin
            sp_update = 1'b1;
            sp_delta  = uop_dir ? delta_pop : delta_push;
         end
      end else if (go && (state == ST_IDLE)) begin
         case (mode)
            MODE_ALU: begin
               if (alu_dec.known) begin
                  exe_cmd       = alu_dec.exe_cmd;
                  wb_en         = alu_dec.wb_en;
                  status_update = alu_dec.is_test ? 1'b1 :
                                  (opcode == OP_AND) ? 1'b0 : status;
               end
            end
            MODE_MEM: begin
               if (!is_list) begin
                  exe_cmd       = EXE_ADD;
                  status_update = status;
                  mem_read      = status;
                  wb_en         = status;
                  mem_write     = !status;
               end
            end
            MODE_BR: begin
               branch        = 1'b1;
               status_update = status;
            end
            default: ;
         endcase
      end
   end

endmodule
